pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
- Parametrised replacement for the hand-written per-stage pipeline registers of the RISC-V core.
- Holds DEPTH stages, each with a valid bit, payload, destination register index and write-enable.
- Supports per-stage stall with bubble insertion and range flush for branch/jump kill.
- Provides a built-in youngest-match forwarding lookup for two source operands, plus a bubble counter for performance monitoring.

Parameters:
- DEPTH, 4, number of stages (min 2); stage 0 youngest, stage DEPTH-1 oldest.
- DATA_W, 32, payload width per stage.
- RD_W, 5, destination register index width.
- IDX_W, $clog2(DEPTH), width of stage index fields.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  new entry offered to stage 0.
- in_data  in  DATA_W  new entry payload.
- in_rd  in  RD_W  new entry destination index.
- in_we  in  1  new entry register-write enable.
- in_ready  out  1  entry accepted this cycle.
- stall_en  in  1  stall request.
- stall_stage  in  IDX_W  highest stage to hold (k).
- flush_en  in  1  flush request.
- flush_stage  in  IDX_W  highest stage to kill (f).
- out_valid  out  1  oldest stage holds a retiring entry.
- out_data  out  DATA_W  oldest stage payload.
- out_rd  out  RD_W  oldest stage destination index.
- out_we  out  1  oldest stage write-enable, gated by valid.
- stage_valid  out  DEPTH  valid bit per stage.
- lookup_rs1  in  RD_W  source index 1.
- lookup_rs2  in  RD_W  source index 2.
- fwd1_hit  out  1  forwarding match for rs1.
- fwd1_sel  out  IDX_W  matching stage index for rs1.
- fwd1_data  out  DATA_W  matching stage payload for rs1.
- fwd2_hit  out  1  forwarding match for rs2.
- fwd2_sel  out  IDX_W  matching stage index for rs2.
- fwd2_data  out  DATA_W  matching stage payload for rs2.
- bubble_cnt  out  CNT_W  cycles with no retirement.

Behaviour:
- Reset: all stage valid/data/rd/we, and bubble_cnt, cleared to 0 at the clock edge with rst=1. rst overrides stall and flush.
- Normal advance (no stall, no flush): s[0] <= {in_valid,in_data,in_rd,in_we}; s[i] <= s[i-1]. Latency from entry to output is DEPTH cycles.
- Stall at k:
  - Stages 0..k hold.
  - Stage k+1 loads a bubble (valid=0; data/rd/we cleared).
  - Stages above k+1 advance.
  - k = DEPTH-1 freezes the whole chain.
- Flush at f: next-state valid and we are cleared for stages 0..f, applied after the stall/advance computation. Flush wins over hold for those stages.
- Out-of-range indices: stall_stage or flush_stage >= DEPTH are clamped to DEPTH-1.
- in_ready = ~stall_en & ~flush_en & ~rst. When in_ready=0 the input is dropped, and the upstream source must re-present it.
- Retirement:
  - out_valid = s[DEPTH-1].valid & ~(stall_en & clamped k = DEPTH-1).
  - out_data/out_rd are driven from s[DEPTH-1] registers.
  - out_we = s[DEPTH-1].we & out_valid.
- Forwarding (combinational from registers, no added latency):
  - A stage i matches rsN when valid, we=1, rd == rsN, and rsN != 0 (x0 never forwards).
  - fwdN_sel is the lowest matching i (youngest producer).
  - fwdN_data = s[sel].data.
  - With no match: hit=0, sel=0, data=0.
- Bubble counter: increments every cycle out_valid=0 after reset, saturates at all-ones, never wraps.
- Simultaneous stall and flush with f >= k+1: the bubble stage is also killed (no effect, already invalid). Stages above f advance normally.

Test Plan:
- Reset then stream 4 entries, in_data 0x10..0x13, rd 1..4, we=1 (DEPTH=4) -> out_valid first high 4 cycles after first accept with out_data=0x10, then 0x11..0x13 on consecutive cycles; bubble_cnt=4 at first retirement.
- Stall k=1 for 1 cycle mid-stream -> stages 0,1 hold; in_ready=0; stage 2 valid=0 next cycle; output shows exactly one retirement gap, order preserved.
- Flush f=1 while stages hold rd 5,6,7,8 -> next cycle stage_valid=4'b1100 (stages 0,1 killed); those entries never retire; in_ready=0 that cycle.
- Stages 0 and 2 both rd=7, we=1, valid; lookup_rs1=7 -> fwd1_hit=1, fwd1_sel=0, fwd1_data=stage 0 payload. lookup_rs2=0 with a stage rd=0 -> fwd2_hit=0.
- stall_stage=7 with DEPTH=4 -> behaves as k=3: full freeze, out_valid=0, bubble_cnt increments.
- Assert rst mid-stream with stall_en=1 -> next cycle all stage_valid=0, bubble_cnt=0; bubble_cnt driven to all-ones then one more idle cycle -> stays all-ones.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline register chain with stall/bubble, range flush, youngest-match forwarding and bubble counter.
// Latency: DEPTH cycles from accept to out_valid; forwarding lookups are combinational from the stage registers.
// Backpressure: in_ready drops during stall, flush or reset, and an unaccepted input is dropped, so upstream must re-present it.
module pipe_stage_chain #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_we,
    output logic              in_ready,
    input  logic              stall_en,
    input  logic [IDX_W-1:0]  stall_stage,
    input  logic              flush_en,
    input  logic [IDX_W-1:0]  flush_stage,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_we,
    output logic [DEPTH-1:0]  stage_valid,
    input  logic [RD_W-1:0]   lookup_rs1,
    input  logic [RD_W-1:0]   lookup_rs2,
    output logic              fwd1_hit,
    output logic [IDX_W-1:0]  fwd1_sel,
    output logic [DATA_W-1:0] fwd1_data,
    output logic              fwd2_hit,
    output logic [IDX_W-1:0]  fwd2_sel,
    output logic [DATA_W-1:0] fwd2_data,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  we_q, we_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [RD_W-1:0]   rd_q   [DEPTH];
    logic [RD_W-1:0]   rd_d   [DEPTH];
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic [IDX_W-1:0] stall_k;
    logic [IDX_W-1:0] flush_f;
    logic             freeze;

    // Index fields can only exceed the last stage when DEPTH is not a power of two.
    generate
        if ((1 << IDX_W) > DEPTH) begin : g_clamp
            assign stall_k = (stall_stage > LAST) ? LAST : stall_stage;
            assign flush_f = (flush_stage > LAST) ? LAST : flush_stage;
        end else begin : g_noclamp
            assign stall_k = stall_stage;
            assign flush_f = flush_stage;
        end
    endgenerate

    assign freeze   = stall_en & (stall_k == LAST);
    assign in_ready = ~stall_en & ~flush_en & ~rst;

    always_comb begin
        valid_d[0] = in_valid & in_ready;
        we_d[0]    = in_we & in_ready;
        data_d[0]  = in_data;
        rd_d[0]    = in_rd;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            we_d[i]    = we_q[i-1];
            data_d[i]  = data_q[i-1];
            rd_d[i]    = rd_q[i-1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (stall_en) begin
                if (i <= int'(stall_k)) begin
                    valid_d[i] = valid_q[i];
                    we_d[i]    = we_q[i];
                    data_d[i]  = data_q[i];
                    rd_d[i]    = rd_q[i];
                end else if (i == int'(stall_k) + 1) begin
                    valid_d[i] = 1'b0;
                    we_d[i]    = 1'b0;
                    data_d[i]  = '0;
                    rd_d[i]    = '0;
                end
            end
            // Flush is applied last so it overrides any hold from the stall.
            if (flush_en && (i <= int'(flush_f))) begin
                valid_d[i] = 1'b0;
                we_d[i]    = 1'b0;
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1] & ~freeze;
    assign out_data  = data_q[DEPTH-1];
    assign out_rd    = rd_q[DEPTH-1];
    assign out_we    = we_q[DEPTH-1] & out_valid;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!out_valid && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            we_q         <= '0;
            bubble_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                rd_q[i]   <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            we_q         <= we_d;
            bubble_cnt_q <= bubble_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
                rd_q[i]   <= rd_d[i];
            end
        end
    end

    assign stage_valid = valid_q;
    assign bubble_cnt  = bubble_cnt_q;

    // Scan oldest to youngest so the youngest producer wins.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_sel  = '0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_sel  = '0;
        fwd2_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && we_q[i] && (rd_q[i] == lookup_rs1) && (lookup_rs1 != '0)) begin
                fwd1_hit  = 1'b1;
                fwd1_sel  = IDX_W'(i);
                fwd1_data = data_q[i];
            end
            if (valid_q[i] && we_q[i] && (rd_q[i] == lookup_rs2) && (lookup_rs2 != '0)) begin
                fwd2_hit  = 1'b1;
                fwd2_sel  = IDX_W'(i);
                fwd2_data = data_q[i];
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: vector table, directed corner sequences and random traffic against a queue-style model.
// Latency: checks are taken each negedge against model state; the model commits its next state at that point.
// Backpressure: rejected inputs are re-presented by the stimulus, mirroring an upstream source.
module tb_pipe_stage_chain;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int IDX_W  = 2;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [RD_W-1:0]   in_rd;
    logic              in_we;
    logic              in_ready;
    logic              stall_en;
    logic [IDX_W-1:0]  stall_stage;
    logic              flush_en;
    logic [IDX_W-1:0]  flush_stage;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd;
    logic              out_we;
    logic [DEPTH-1:0]  stage_valid;
    logic [RD_W-1:0]   lookup_rs1;
    logic [RD_W-1:0]   lookup_rs2;
    logic              fwd1_hit;
    logic [IDX_W-1:0]  fwd1_sel;
    logic [DATA_W-1:0] fwd1_data;
    logic              fwd2_hit;
    logic [IDX_W-1:0]  fwd2_sel;
    logic [DATA_W-1:0] fwd2_data;
    logic [CNT_W-1:0]  bubble_cnt;

    pipe_stage_chain #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .RD_W(RD_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_rd(in_rd), .in_we(in_we), .in_ready(in_ready),
        .stall_en(stall_en), .stall_stage(stall_stage),
        .flush_en(flush_en), .flush_stage(flush_stage),
        .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd), .out_we(out_we),
        .stage_valid(stage_valid),
        .lookup_rs1(lookup_rs1), .lookup_rs2(lookup_rs2),
        .fwd1_hit(fwd1_hit), .fwd1_sel(fwd1_sel), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_sel(fwd2_sel), .fwd2_data(fwd2_data),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: one record per stage, index 0 youngest.
    bit          m_v  [DEPTH];
    bit          m_we [DEPTH];
    logic [31:0] m_d  [DEPTH];
    logic [4:0]  m_rd [DEPTH];
    int          m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void find(input logic [4:0] rs, output bit h, output int sel, output logic [31:0] d);
        h = 0; sel = 0; d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!h && m_v[i] && m_we[i] && (m_rd[i] == rs) && (rs != 0)) begin
                h = 1; sel = i; d = m_d[i];
            end
        end
    endfunction

    task automatic check_model();
        int kc, fc, sel;
        bit e_rdy, e_ov, h;
        logic [31:0] fd;
        logic [DEPTH-1:0] e_sv;
        bit          n_v  [DEPTH];
        bit          n_we [DEPTH];
        logic [31:0] n_d  [DEPTH];
        logic [4:0]  n_rd [DEPTH];
        kc = (int'(stall_stage) >= DEPTH) ? DEPTH - 1 : int'(stall_stage);
        fc = (int'(flush_stage) >= DEPTH) ? DEPTH - 1 : int'(flush_stage);
        e_rdy = !stall_en && !flush_en && !rst;
        e_ov  = m_v[DEPTH-1] && !(stall_en && kc == DEPTH - 1);
        chk("in_ready", 64'(in_ready), 64'(e_rdy));
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        chk("out_we", 64'(out_we), 64'(m_we[DEPTH-1] && e_ov));
        if (e_ov) begin
            chk("out_data", 64'(out_data), 64'(m_d[DEPTH-1]));
            chk("out_rd", 64'(out_rd), 64'(m_rd[DEPTH-1]));
        end
        for (int i = 0; i < DEPTH; i++) e_sv[i] = m_v[i];
        chk("stage_valid", 64'(stage_valid), 64'(e_sv));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
        find(lookup_rs1, h, sel, fd);
        chk("fwd1_hit", 64'(fwd1_hit), 64'(h));
        chk("fwd1_sel", 64'(fwd1_sel), 64'(sel));
        chk("fwd1_data", 64'(fwd1_data), 64'(fd));
        find(lookup_rs2, h, sel, fd);
        chk("fwd2_hit", 64'(fwd2_hit), 64'(h));
        chk("fwd2_sel", 64'(fwd2_sel), 64'(sel));
        chk("fwd2_data", 64'(fwd2_data), 64'(fd));

        // Next state: everything moves one place older, then stall and flush rules apply.
        for (int i = DEPTH - 1; i > 0; i--) begin
            n_v[i] = m_v[i-1]; n_we[i] = m_we[i-1]; n_d[i] = m_d[i-1]; n_rd[i] = m_rd[i-1];
        end
        n_v[0] = in_valid && e_rdy; n_we[0] = in_we && e_rdy; n_d[0] = in_data; n_rd[0] = in_rd;
        if (stall_en) begin
            for (int i = 0; i <= kc; i++) begin
                n_v[i] = m_v[i]; n_we[i] = m_we[i]; n_d[i] = m_d[i]; n_rd[i] = m_rd[i];
            end
            if (kc + 1 < DEPTH) begin
                n_v[kc+1] = 0; n_we[kc+1] = 0; n_d[kc+1] = '0; n_rd[kc+1] = '0;
            end
        end
        if (flush_en) begin
            for (int i = 0; i <= fc; i++) begin
                n_v[i] = 0; n_we[i] = 0;
            end
        end
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                n_v[i] = 0; n_we[i] = 0; n_d[i] = '0; n_rd[i] = '0;
            end
            m_cnt = 0;
        end else if (!e_ov && m_cnt < CNT_MAX) begin
            m_cnt++;
        end
        m_v = n_v; m_we = n_we; m_d = n_d; m_rd = n_rd;
    endtask

    task automatic sample();
        @(negedge clk);
        check_model();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_data = '0; in_rd = '0; in_we = 0;
        stall_en = 0; stall_stage = '0; flush_en = 0; flush_stage = '0;
    endtask

    task automatic push(input logic [31:0] d, input logic [4:0] r);
        idle_inputs();
        in_valid = 1; in_data = d; in_rd = r; in_we = 1;
        sample();
        adv();
    endtask

    typedef struct {
        bit          v;
        logic [31:0] d;
        logic [4:0]  rd;
        bit          st;
        logic [1:0]  k;
        bit          ov;
        logic [31:0] od;
        logic [3:0]  sv;
        int          bub;
        bit          rdy;
    } vec_t;

    vec_t tbl [20];
    bit   seen_rd8;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_v[i] = 0; m_we[i] = 0; m_d[i] = '0; m_rd[i] = '0;
        end
        m_cnt = 0;
        idle_inputs();
        lookup_rs1 = '0; lookup_rs2 = '0;
        rst = 1;

        tbl[0]  = '{1, 32'h10, 5'd1, 0, 2'd0, 0, 32'h00, 4'b0000, 0, 1};
        tbl[1]  = '{1, 32'h11, 5'd2, 0, 2'd0, 0, 32'h00, 4'b0001, 1, 1};
        tbl[2]  = '{1, 32'h12, 5'd3, 0, 2'd0, 0, 32'h00, 4'b0011, 2, 1};
        tbl[3]  = '{1, 32'h13, 5'd4, 0, 2'd0, 0, 32'h00, 4'b0111, 3, 1};
        tbl[4]  = '{0, 32'h00, 5'd0, 0, 2'd0, 1, 32'h10, 4'b1111, 4, 1};
        tbl[5]  = '{0, 32'h00, 5'd0, 0, 2'd0, 1, 32'h11, 4'b1110, 4, 1};
        tbl[6]  = '{0, 32'h00, 5'd0, 0, 2'd0, 1, 32'h12, 4'b1100, 4, 1};
        tbl[7]  = '{0, 32'h00, 5'd0, 0, 2'd0, 1, 32'h13, 4'b1000, 4, 1};
        tbl[8]  = '{0, 32'h00, 5'd0, 0, 2'd0, 0, 32'h00, 4'b0000, 4, 1};
        tbl[9]  = '{1, 32'h20, 5'd1, 0, 2'd0, 0, 32'h00, 4'b0000, 5, 1};
        tbl[10] = '{1, 32'h21, 5'd2, 0, 2'd0, 0, 32'h00, 4'b0001, 6, 1};
        tbl[11] = '{1, 32'h22, 5'd3, 0, 2'd0, 0, 32'h00, 4'b0011, 7, 1};
        tbl[12] = '{1, 32'h23, 5'd4, 0, 2'd0, 0, 32'h00, 4'b0111, 8, 1};
        tbl[13] = '{1, 32'h24, 5'd5, 1, 2'd1, 1, 32'h20, 4'b1111, 9, 0};
        tbl[14] = '{1, 32'h24, 5'd5, 0, 2'd0, 1, 32'h21, 4'b1011, 9, 1};
        tbl[15] = '{0, 32'h00, 5'd0, 0, 2'd0, 0, 32'h00, 4'b0111, 9, 1};
        tbl[16] = '{0, 32'h00, 5'd0, 0, 2'd0, 1, 32'h22, 4'b1110, 10, 1};
        tbl[17] = '{0, 32'h00, 5'd0, 0, 2'd0, 1, 32'h23, 4'b1100, 10, 1};
        tbl[18] = '{0, 32'h00, 5'd0, 0, 2'd0, 1, 32'h24, 4'b1000, 10, 1};
        tbl[19] = '{0, 32'h00, 5'd0, 0, 2'd0, 0, 32'h00, 4'b0000, 10, 1};

        #1;
        sample();
        adv();
        rst = 0;

        // Streaming and one-cycle stall at k=1.
        for (int r = 0; r < 20; r++) begin
            idle_inputs();
            in_valid = tbl[r].v; in_data = tbl[r].d; in_rd = tbl[r].rd; in_we = tbl[r].v;
            stall_en = tbl[r].st; stall_stage = tbl[r].k;
            sample();
            chk($sformatf("tbl%0d.in_ready", r), 64'(in_ready), 64'(tbl[r].rdy));
            chk($sformatf("tbl%0d.out_valid", r), 64'(out_valid), 64'(tbl[r].ov));
            if (tbl[r].ov) chk($sformatf("tbl%0d.out_data", r), 64'(out_data), 64'(tbl[r].od));
            chk($sformatf("tbl%0d.stage_valid", r), 64'(stage_valid), 64'(tbl[r].sv));
            chk($sformatf("tbl%0d.bubble_cnt", r), 64'(bubble_cnt), 64'(tbl[r].bub));
            adv();
        end

        // Range flush of stages 0..1 while rd 5..8 are in flight.
        push(32'h50, 5'd5); push(32'h60, 5'd6); push(32'h70, 5'd7); push(32'h80, 5'd8);
        idle_inputs();
        in_valid = 1; in_data = 32'h90; in_rd = 5'd9; in_we = 1;
        flush_en = 1; flush_stage = 2'd1;
        sample();
        chk("flush.in_ready", 64'(in_ready), 64'(0));
        chk("flush.out_rd", 64'(out_rd), 64'(5));
        adv();
        idle_inputs();
        seen_rd8 = 0;
        for (int c = 0; c < 6; c++) begin
            sample();
            if (c == 0) chk("flush.stage_valid", 64'(stage_valid), 64'(4'b1100));
            if (out_valid && (out_rd == 5'd8 || out_rd == 5'd9)) seen_rd8 = 1;
            adv();
        end
        chk("flush.killed_retired", 64'(seen_rd8), 64'(0));

        // Forwarding: stages 0 and 2 both write x7, stage 3 writes x0.
        push(32'hD0, 5'd0); push(32'hA7, 5'd7); push(32'hB3, 5'd3); push(32'hC7, 5'd7);
        idle_inputs();
        lookup_rs1 = 5'd7; lookup_rs2 = 5'd0;
        sample();
        chk("fwd.hit1", 64'(fwd1_hit), 64'(1));
        chk("fwd.sel1", 64'(fwd1_sel), 64'(0));
        chk("fwd.data1", 64'(fwd1_data), 64'(32'hC7));
        chk("fwd.hit2_x0", 64'(fwd2_hit), 64'(0));
        chk("fwd.data2_x0", 64'(fwd2_data), 64'(0));
        adv();
        sample();
        chk("fwd.sel1_aged", 64'(fwd1_sel), 64'(1));
        chk("fwd.data1_aged", 64'(fwd1_data), 64'(32'hC7));
        adv();

        // Out-of-range stall index behaves as a full freeze.
        push(32'h61, 5'd1); push(32'h62, 5'd2); push(32'h63, 5'd3); push(32'h64, 5'd4);
        for (int c = 0; c < 3; c++) begin
            idle_inputs();
            stall_en = 1; stall_stage = IDX_W'(7);
            sample();
            chk("freeze.out_valid", 64'(out_valid), 64'(0));
            chk("freeze.stage_valid", 64'(stage_valid), 64'(4'b1111));
            adv();
        end

        // Reset mid-stream while stalled.
        idle_inputs();
        in_valid = 1; in_data = 32'h77; in_rd = 5'd7; in_we = 1;
        stall_en = 1; stall_stage = 2'd1; rst = 1;
        sample();
        chk("rst.in_ready", 64'(in_ready), 64'(0));
        adv();
        rst = 0;
        idle_inputs();
        sample();
        chk("rst.stage_valid", 64'(stage_valid), 64'(0));
        chk("rst.bubble_cnt", 64'(bubble_cnt), 64'(0));
        adv();

        // Saturate the bubble counter and hold there.
        for (int c = 0; c < CNT_MAX + 4; c++) begin
            sample();
            adv();
        end
        sample();
        chk("sat.bubble_cnt", 64'(bubble_cnt), 64'(CNT_MAX));
        adv();
        sample();
        chk("sat.bubble_cnt_hold", 64'(bubble_cnt), 64'(CNT_MAX));
        adv();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            rst         = ($urandom_range(0, 79) == 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            in_data     = $urandom;
            in_rd       = 5'($urandom_range(0, 7));
            in_we       = ($urandom_range(0, 3) != 0);
            stall_en    = ($urandom_range(0, 4) == 0);
            stall_stage = IDX_W'($urandom_range(0, 3));
            flush_en    = ($urandom_range(0, 7) == 0);
            flush_stage = IDX_W'($urandom_range(0, 3));
            lookup_rs1  = 5'($urandom_range(0, 7));
            lookup_rs2  = 5'($urandom_range(0, 7));
            sample();
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
